// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   - rx_state_e : receiver FSM state encoding
//   - majority3  : two-of-three vote used for bit sampling
//   - DEFAULT_*  : constants the baud tick generator is built around
// Ports: none (package).
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_e;

    localparam int unsigned DEFAULT_CLK_HZ     = 50_000_000;
    localparam int unsigned DEFAULT_BAUD       = 115_200;
    localparam int unsigned DEFAULT_OVERSAMPLE = 16;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync_edge.sv
// Two-flop synchroniser for an idle-high asynchronous line plus a falling-edge
// detector on the synchronised value. Also used for the transmitter's CTS input.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset (flops reset to 1)
//   i_async        : asynchronous input line
//   o_sync         : synchronised line value
//   o_fall         : single-cycle pulse when o_sync goes 1 -> 0
module uart_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_fall
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], i_async};
            prev_q <= sync_q[1];
        end
    end

    assign o_sync = sync_q[1];
    assign o_fall = prev_q & ~sync_q[1];

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: DATA_BITS data bits LSB first, optional parity,
// STOP_BITS stop bits, OVERSAMPLE baud ticks per bit, majority-of-three sampling
// at ticks MID-1, MID, MID+1 (MID = OVERSAMPLE/2 - 1).
// Build option: define UART_RX_PARITY_EN to include the parity bit and check.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_rx_serial    : asynchronous serial line, idle high
//   i_baud_tick    : one-cycle pulse at OVERSAMPLE x baud
//   o_rx_data      : received word, held while o_rx_valid
//   o_rx_valid     : word available until accepted (valid && i_rx_ready)
//   i_rx_ready     : consumer ready
//   o_frame_err    : a stop bit was low (qualified by o_rx_valid)
//   o_parity_err   : parity mismatch (qualified by o_rx_valid), 0 if compiled out
//   o_overrun      : one-cycle pulse when a frame is dropped because a word is pending
//   o_busy         : FSM not idle
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_rx_serial,
    input  logic                 i_baud_tick,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    input  logic                 i_rx_ready,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] SMP_A    = TICK_W'(OVERSAMPLE / 2 - 2);
    localparam logic [TICK_W-1:0] SMP_B    = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] SMP_C    = TICK_W'(OVERSAMPLE / 2);
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);
    localparam logic              LAST_STP = 1'(STOP_BITS - 1);

    logic rxs, rx_fall;

    uart_sync_edge u_sync_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_rx_serial),
        .o_sync  (rxs),
        .o_fall  (rx_fall)
    );

    rx_state_e            state_q, state_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [1:0]           smp_q, smp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 ferr_acc_q, ferr_acc_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 perr_now;
`ifdef UART_RX_PARITY_EN
    logic                 par_acc_q, par_acc_d;
    logic                 perr_acc_q, perr_acc_d;
    logic                 perr_q, perr_d;
`endif

    logic vote, at_c, complete;

    // The third sample is the live line value at MID+1; the vote is used there.
    assign vote = majority3(smp_q[0], smp_q[1], rxs);
    assign at_c = i_baud_tick && (tick_q == SMP_C);

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        stop_d     = stop_q;
        smp_d      = smp_q;
        shift_d    = shift_q;
        ferr_acc_d = ferr_acc_q;
        complete   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_acc_d  = par_acc_q;
        perr_acc_d = perr_acc_q;
`endif

        if (i_baud_tick) begin
            tick_d = (tick_q == TICK_MAX) ? '0 : tick_q + TICK_W'(1);
            if (tick_q == SMP_A) smp_d[0] = rxs;
            if (tick_q == SMP_B) smp_d[1] = rxs;
        end

        unique case (state_q)
            StIdle: begin
                tick_d = '0;
                if (rx_fall) begin
                    state_d    = StStart;
                    bit_d      = '0;
                    stop_d     = 1'b0;
                    ferr_acc_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                    par_acc_d  = 1'b0;
                    perr_acc_d = 1'b0;
`endif
                end
            end
            StStart: begin
                if (at_c) state_d = vote ? StIdle : StData;
            end
            StData: begin
                if (at_c) begin
                    shift_d = {vote, shift_q[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
                    par_acc_d = par_acc_q ^ vote;
`endif
                    if (bit_q == LAST_BIT) begin
                        bit_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (at_c) begin
                    perr_acc_d = (par_acc_q ^ vote) != 1'(PARITY_ODD);
                    state_d    = StStop;
                end
            end
`endif
            StStop: begin
                if (at_c) begin
                    if (!vote) ferr_acc_d = 1'b1;
                    if (stop_q == LAST_STP) begin
                        complete = 1'b1;
                        state_d  = StIdle;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign perr_now = perr_acc_q;
`else
    assign perr_now = 1'b0;
`endif

    // Output side: load on completion if the slot is free or being freed this cycle.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d  = perr_q;
`endif
        if (complete) begin
            if (!valid_q || i_rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
                ferr_d  = ferr_acc_q | ~vote;
`ifdef UART_RX_PARITY_EN
                perr_d  = perr_now;
`endif
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && i_rx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            tick_q     <= '0;
            bit_q      <= '0;
            stop_q     <= 1'b0;
            smp_q      <= 2'b11;
            shift_q    <= '0;
            ferr_acc_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_acc_q  <= 1'b0;
            perr_acc_q <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            stop_q     <= stop_d;
            smp_q      <= smp_d;
            shift_q    <= shift_d;
            ferr_acc_q <= ferr_acc_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
`ifdef UART_RX_PARITY_EN
            par_acc_q  <= par_acc_d;
            perr_acc_q <= perr_acc_d;
            perr_q     <= perr_d;
`endif
        end
    end

    assign o_rx_data   = data_q;
    assign o_rx_valid  = valid_q;
    assign o_frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = perr_q;
`else
    assign o_parity_err = 1'b0;
`endif
    assign o_overrun   = ovr_q;
    assign o_busy      = (state_q != StIdle);

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver, the next generation of the fixed 8N1 receiver. It sits between the pad-side serial line and the byte-stream consumer, driven by the shared 16x-style baud tick generator. It adds configurable word length, stop bits and oversampling, optional parity, and majority-vote sampling. It also adds a ready/valid output with overrun detection and per-frame error flags.

## Interface
Parameters:
- DATA_BITS, 8, data bits per frame (5–9), LSB first
- OVERSAMPLE, 16, baud ticks per bit (even, 8–32)
- STOP_BITS, 1, stop bits checked (1 or 2)
- PARITY_ODD, 0, 1 = odd parity, 0 = even (only with UART_RX_PARITY_EN)

Ports:
- i_clk  in  1  system clock, single clock domain
- i_rst_n  in  1  asynchronous, active-low reset
- i_rx_serial  in  1  asynchronous serial line, idle high
- i_baud_tick  in  1  one-cycle pulse at OVERSAMPLE × baud rate
- o_rx_data  out  DATA_BITS  received word, held while o_rx_valid
- o_rx_valid  out  1  word available; held until accepted
- i_rx_ready  in  1  consumer accepts when valid && ready
- o_frame_err  out  1  a stop bit sampled low; qualified by o_rx_valid
- o_parity_err  out  1  parity mismatch; qualified by o_rx_valid; 0 when parity compiled out
- o_overrun  out  1  one-cycle pulse; frame completed while previous word still pending
- o_busy  out  1  FSM not in IDLE

## Operation
- i_rx_serial passes through a 2-flop synchroniser (reset to 1). All logic uses the synchronised value `rxs`.
- MID = OVERSAMPLE/2 − 1. Each bit is sampled at ticks MID−1, MID and MID+1 of the bit. The bit value is the majority of those three samples.
- FSM states and transitions:
  - IDLE → START on a falling edge of `rxs`; tick counter cleared.
  - START: at tick MID+1, a majority-low start bit → DATA. Otherwise it is a glitch → IDLE.
  - DATA: the bit counter runs 0..DATA_BITS−1. The voted bit is shifted in LSB first at MID+1. The tick counter wraps at OVERSAMPLE−1. After the last bit → PARITY if compiled in, else → STOP.
  - PARITY: the voted bit is XORed with the data bits. o_parity_err is set if the result ≠ PARITY_ODD.
  - STOP: each stop bit is voted at MID+1; any low stop bit sets the frame error. The frame completes at MID+1 of the last stop bit, then → IDLE. Returning at mid-bit allows the next start edge to be caught.
- Completion rules:
  - If o_rx_valid is 0, or is being accepted in the same cycle: o_rx_data, o_frame_err and o_parity_err load and o_rx_valid is set.
  - Otherwise the new word is dropped, the pending word is kept, and o_overrun pulses for one cycle.
- Frames with errors are still delivered, with the flags set.
- While o_rx_valid is 1 and i_rx_ready is 1: valid clears on the next edge.
- Counters are sized $clog2(OVERSAMPLE) and $clog2(DATA_BITS+1). No arithmetic overflow is possible.

## Timing
- Reset values: o_rx_data=0, o_rx_valid=0, o_frame_err=0, o_parity_err=0, o_overrun=0, o_busy=0. FSM in IDLE, synchroniser at 1.
- Reset mid-frame aborts the frame immediately with no output.
- Input-to-edge-detect latency is 2 clocks.
- o_rx_valid rises one clock after the completing baud tick.
- Ticks are only counted on i_baud_tick cycles. Edge detection in IDLE runs every clock.
- If acceptance and completion fall in the same cycle, the new word loads, valid stays 1, and there is no overrun.

## Configuration
- With `UART_RX_PARITY_EN` defined: the PARITY state exists, and o_parity_err reports mismatches per PARITY_ODD.
- Without it: there is no PARITY state, STOP directly follows DATA, and o_parity_err is tied to 0.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP)
  - majority-of-three function
  - default baud/oversample constants used with the tick generator
- One natural sub-module: `uart_sync_edge`, the 2-flop synchroniser plus falling-edge detector, reusable by the transmitter's CTS input.

## Test plan
- 8N1, OVERSAMPLE=16: send 0xA5. Expect o_rx_data=0xA5 with o_rx_valid held until ready, and both error flags 0.
- DATA_BITS=7, STOP_BITS=2, parity enabled and even: send 0x55 with wrong parity. Expect data 0x55 and o_parity_err=1.
- Second stop bit driven low: expect o_frame_err=1 with data still delivered.
- Start pulse low for 4 ticks only: expect return to IDLE, no valid, and o_busy back to 0.
- Keep i_rx_ready=0 and send 0x11 then 0x22. Expect o_overrun to pulse once and o_rx_data to remain 0x11.
- Single-tick glitch at the mid-sample of data bit 3 of 0x00: majority vote yields 0x00.
- Assert reset during DATA: all outputs return to 0. The next clean frame 0x3C is received correctly.
